// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master
//   Single-outstanding AXI4-Lite master. A local command/response handshake
//   is turned into one AXI4-Lite write (AW+W then B) or read (AR then R).
//
// Ports
//   M_AXI_ACLK, M_AXI_ARESET   clock, asynchronous active-high reset
//   cmd_valid/cmd_ready        command handshake; cmd_write selects write/read
//   cmd_addr/wdata/wstrb       command payload, registered on accept
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata/resp/timeout     read data (0 for writes), BRESP/RRESP, watchdog
//   busy                       high whenever the FSM is not idle
//   M_AXI_*                    AXI4-Lite master channels AW, W, B, AR, R
//
// Build option
//   AXI_CMD_MASTER_TIMEOUT_EN  enables a TIMEOUT_CYCLES watchdog. On expiry
//                              the command is answered with SLVERR and
//                              rsp_timeout=1; the still-open AXI transaction
//                              is then completed and its response discarded
//                              in the DRAIN state.
//
// States
//   IDLE    | waiting for a command, cmd_ready=1
//   WR_REQ  | AWVALID/WVALID up, each drops after its own handshake
//   WR_RESP | BREADY=1, waiting for BVALID
//   RD_REQ  | ARVALID=1, waiting for ARREADY
//   RD_RESP | RREADY=1, waiting for RVALID
//   RSP     | rsp_valid=1 until rsp_ready
//   DRAIN   | (watchdog build) finish the abandoned transaction silently

module axi_lite_cmd_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 5,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESET,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_timeout,
    output logic                            busy,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

`ifdef AXI_CMD_MASTER_TIMEOUT_EN
    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_RSP, S_DRAIN
    } state_t;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
`else
    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_RSP
    } state_t;
`endif

    state_t                            state_q, state_d;
    logic                              wr_q, wr_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [C_M_AXI_DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
    logic                              aw_done_q, aw_done_d;
    logic                              w_done_q, w_done_d;
    logic                              ar_done_q, ar_done_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic [1:0]                        resp_q, resp_d;
    logic                              hold_valids;
`ifdef AXI_CMD_MASTER_TIMEOUT_EN
    logic                              to_q, to_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
`endif

    // After a timeout the AXI transaction is still open: VALIDs that have not
    // handshaken must stay up through RSP and DRAIN to remain AXI-legal.
`ifdef AXI_CMD_MASTER_TIMEOUT_EN
    assign hold_valids = (state_q == S_DRAIN) || (state_q == S_RSP && to_q);
    assign rsp_timeout = to_q;
`else
    assign hold_valids = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    assign cmd_ready     = (state_q == S_IDLE) && !M_AXI_ARESET;
    assign busy          = (state_q != S_IDLE);
    assign rsp_valid     = (state_q == S_RSP);
    assign rsp_rdata     = rdata_q;
    assign rsp_resp      = resp_q;

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_AWVALID = wr_q && !aw_done_q && (state_q == S_WR_REQ || hold_valids);
    assign M_AXI_WVALID  = wr_q && !w_done_q && (state_q == S_WR_REQ || hold_valids);
    assign M_AXI_ARVALID = !wr_q && !ar_done_q && (state_q == S_RD_REQ || hold_valids);
`ifdef AXI_CMD_MASTER_TIMEOUT_EN
    assign M_AXI_BREADY  = (state_q == S_WR_RESP) ||
                           (state_q == S_DRAIN && wr_q && aw_done_q && w_done_q);
    assign M_AXI_RREADY  = (state_q == S_RD_RESP) ||
                           (state_q == S_DRAIN && !wr_q && ar_done_q);
`else
    assign M_AXI_BREADY  = (state_q == S_WR_RESP);
    assign M_AXI_RREADY  = (state_q == S_RD_RESP);
`endif

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q || (M_AXI_AWVALID && M_AXI_AWREADY);
        w_done_d  = w_done_q  || (M_AXI_WVALID  && M_AXI_WREADY);
        ar_done_d = ar_done_q || (M_AXI_ARVALID && M_AXI_ARREADY);
        rdata_d   = rdata_q;
        resp_d    = resp_q;
`ifdef AXI_CMD_MASTER_TIMEOUT_EN
        to_d      = to_q;
        cnt_d     = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    wr_d      = cmd_write;
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    ar_done_d = 1'b0;
`ifdef AXI_CMD_MASTER_TIMEOUT_EN
                    to_d      = 1'b0;
                    cnt_d     = '0;
`endif
                    state_d   = cmd_write ? S_WR_REQ : S_RD_REQ;
                end
            end
            S_WR_REQ:  if (aw_done_d && w_done_d) state_d = S_WR_RESP;
            S_WR_RESP: begin
                if (M_AXI_BVALID) begin
                    resp_d  = M_AXI_BRESP;
                    rdata_d = '0;
                    state_d = S_RSP;
                end
            end
            S_RD_REQ:  if (M_AXI_ARREADY) state_d = S_RD_RESP;
            S_RD_RESP: begin
                if (M_AXI_RVALID) begin
                    resp_d  = M_AXI_RRESP;
                    rdata_d = M_AXI_RDATA;
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
`ifdef AXI_CMD_MASTER_TIMEOUT_EN
                    state_d = to_q ? S_DRAIN : S_IDLE;
`else
                    state_d = S_IDLE;
`endif
                end
            end
`ifdef AXI_CMD_MASTER_TIMEOUT_EN
            S_DRAIN: begin
                if ((M_AXI_BVALID && M_AXI_BREADY) || (M_AXI_RVALID && M_AXI_RREADY))
                    state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
`ifdef AXI_CMD_MASTER_TIMEOUT_EN
        // A response completing in the same cycle wins over the watchdog,
        // otherwise the consumed B/R would be waited for again in DRAIN.
        if (state_q == S_WR_REQ || state_q == S_WR_RESP ||
            state_q == S_RD_REQ || state_q == S_RD_RESP) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1) && state_d != S_RSP) begin
                state_d = S_RSP;
                to_d    = 1'b1;
                resp_d  = 2'b10;
                rdata_d = '0;
            end
        end
`endif
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state_q   <= S_IDLE;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            ar_done_q <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= '0;
`ifdef AXI_CMD_MASTER_TIMEOUT_EN
            to_q      <= 1'b0;
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            ar_done_q <= ar_done_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
`ifdef AXI_CMD_MASTER_TIMEOUT_EN
            to_q      <= to_d;
            cnt_q     <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Testbench for axi_lite_cmd_master: AXI4-Lite slave model with programmable
// READY/response latencies, scoreboard of expected responses, and checks of
// channel timing, payload, and VALID stability.

module tb_axi_lite_cmd_master;

    localparam int BUDGET = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [4:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout, busy;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [4:0]  M_AXI_AWADDR, M_AXI_ARADDR;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [31:0] M_AXI_WDATA, M_AXI_RDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;

    always #5 clk = ~clk;

    axi_lite_cmd_master #(
        .C_M_AXI_ADDR_WIDTH(5), .C_M_AXI_DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
    ) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        to;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    int tests_run = 0;
    int tests_failed = 0;

    // ---------------- slave model ----------------
    // Latencies count cycles a VALID is seen before READY is raised; B/R
    // latencies count cycles after the request handshake before VALID.
    int          aw_lat = 0, w_lat = 0, ar_lat = 0, b_lat = 0, r_lat = 0;
    logic [31:0] s_rdata = 0;
    logic [1:0]  s_rresp = 0, s_bresp = 0;

    int   aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt, pend_b, pend_r;
    bit   aw_got, w_got, b_hs, r_hs;
    int   b_consumed = 0, r_consumed = 0, viol = 0;
    logic [4:0]  cap_awaddr = 0, cap_araddr = 0;
    logic [31:0] cap_wdata = 0;
    logic [3:0]  cap_wstrb = 0;
    logic [2:0]  cap_prot = 0;
    logic pv_aw, pr_aw, pv_w, pr_w, pv_ar, pr_ar;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
            M_AXI_BVALID = 0; M_AXI_RVALID = 0; M_AXI_BRESP = 0; M_AXI_RRESP = 0; M_AXI_RDATA = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0; pend_b = 0; pend_r = 0;
            aw_got = 0; w_got = 0; b_hs = 0; r_hs = 0;
            pv_aw = 0; pr_aw = 0; pv_w = 0; pr_w = 0; pv_ar = 0; pr_ar = 0;
        end else begin
            // a VALID without READY at the last edge must still be asserted
            if (pv_aw && !pr_aw && !M_AXI_AWVALID) viol++;
            if (pv_w  && !pr_w  && !M_AXI_WVALID)  viol++;
            if (pv_ar && !pr_ar && !M_AXI_ARVALID) viol++;
            if (M_AXI_AWVALID && M_AXI_ARVALID) viol++;
            // B channel
            if (b_hs) begin pend_b--; b_hs = 0; M_AXI_BVALID = 0; b_cnt = 0; end
            if (pend_b > 0 && !M_AXI_BVALID) begin
                if (b_cnt >= b_lat) begin M_AXI_BVALID = 1; M_AXI_BRESP = s_bresp; end
                else b_cnt++;
            end
            if (M_AXI_BVALID && M_AXI_BREADY) begin b_hs = 1; b_consumed++; end
            // R channel
            if (r_hs) begin pend_r--; r_hs = 0; M_AXI_RVALID = 0; r_cnt = 0; end
            if (pend_r > 0 && !M_AXI_RVALID) begin
                if (r_cnt >= r_lat) begin
                    M_AXI_RVALID = 1; M_AXI_RRESP = s_rresp; M_AXI_RDATA = s_rdata;
                end else r_cnt++;
            end
            if (M_AXI_RVALID && M_AXI_RREADY) begin r_hs = 1; r_consumed++; end
            // request channels
            if (M_AXI_AWVALID) begin M_AXI_AWREADY = (aw_cnt >= aw_lat); aw_cnt++; end
            else begin M_AXI_AWREADY = 0; aw_cnt = 0; end
            if (M_AXI_WVALID) begin M_AXI_WREADY = (w_cnt >= w_lat); w_cnt++; end
            else begin M_AXI_WREADY = 0; w_cnt = 0; end
            if (M_AXI_ARVALID) begin M_AXI_ARREADY = (ar_cnt >= ar_lat); ar_cnt++; end
            else begin M_AXI_ARREADY = 0; ar_cnt = 0; end
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                aw_got = 1; cap_awaddr = M_AXI_AWADDR; cap_prot = cap_prot | M_AXI_AWPROT;
            end
            if (M_AXI_WVALID && M_AXI_WREADY) begin
                w_got = 1; cap_wdata = M_AXI_WDATA; cap_wstrb = M_AXI_WSTRB;
            end
            if (aw_got && w_got) begin pend_b++; aw_got = 0; w_got = 0; end
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                pend_r++; cap_araddr = M_AXI_ARADDR; cap_prot = cap_prot | M_AXI_ARPROT;
            end
            pv_aw = M_AXI_AWVALID; pr_aw = M_AXI_AWREADY;
            pv_w  = M_AXI_WVALID;  pr_w  = M_AXI_WREADY;
            pv_ar = M_AXI_ARVALID; pr_ar = M_AXI_ARREADY;
        end
    end

    // ---------------- command driver / observer ----------------
    int          obs_aw_first, obs_aw_last, obs_w_first, obs_w_last;
    int          obs_bready_first, obs_ar_first, obs_rready_first;
    int          obs_rsp_cyc, obs_rsp_len, obs_unstable;
    logic [31:0] obs_rdata;
    logic [1:0]  obs_resp;
    logic        obs_to, obs_ready0, obs_ready_after, obs_rsp_after;

    // Cycle 0 is the cycle in which the command is accepted.
    task automatic run_cmd(input logic wr, input logic [4:0] addr, input logic [31:0] wd,
                           input logic [3:0] ws, input int hold);
        bit done = 0;
        obs_aw_first = -1; obs_aw_last = -1; obs_w_first = -1; obs_w_last = -1;
        obs_bready_first = -1; obs_ar_first = -1; obs_rready_first = -1;
        obs_rsp_cyc = -1; obs_rsp_len = 0; obs_unstable = 0;
        obs_rdata = 'x; obs_resp = 'x; obs_to = 'x;
        @(negedge clk);
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
        rsp_ready = 0;
        obs_ready0 = cmd_ready;
        for (int c = 1; c <= BUDGET && !done; c++) begin
            @(negedge clk);
            cmd_valid = 0; cmd_addr = 5'($urandom); cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
            if (M_AXI_AWVALID) begin if (obs_aw_first < 0) obs_aw_first = c; obs_aw_last = c; end
            if (M_AXI_WVALID)  begin if (obs_w_first < 0)  obs_w_first = c;  obs_w_last = c;  end
            if (M_AXI_BREADY && obs_bready_first < 0) obs_bready_first = c;
            if (M_AXI_ARVALID && obs_ar_first < 0) obs_ar_first = c;
            if (M_AXI_RREADY && obs_rready_first < 0) obs_rready_first = c;
            if (rsp_valid) begin
                if (obs_rsp_cyc < 0) begin
                    obs_rsp_cyc = c; obs_rdata = rsp_rdata; obs_resp = rsp_resp; obs_to = rsp_timeout;
                end else if (rsp_rdata !== obs_rdata || rsp_resp !== obs_resp || rsp_timeout !== obs_to)
                    obs_unstable++;
                if (cmd_ready) obs_unstable++;
                obs_rsp_len++;
                rsp_ready = (c - obs_rsp_cyc >= hold);
                if (rsp_ready) done = 1;
            end
        end
        @(negedge clk);
        rsp_ready = 0;
        obs_ready_after = cmd_ready;
        obs_rsp_after = rsp_valid;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
        repeat (3) @(negedge clk);
        tests_run++; if (cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_cmd_ready: got %b expected 0", cmd_ready); end
        tests_run++;
        if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY, rsp_valid, busy} !== 7'b0) begin
            tests_failed++; $display("FAIL rst_handshakes: got %b expected 0",
                {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY, rsp_valid, busy});
        end
        tests_run++;
        if ({rsp_rdata, rsp_resp, rsp_timeout} !== 35'h0) begin
            tests_failed++; $display("FAIL rst_rsp_fields: got %h/%b/%b expected 0", rsp_rdata, rsp_resp, rsp_timeout);
        end
        rst = 0;
        #1;
        tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_release_ready: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_write_zero_wait();
        aw_lat = 0; w_lat = 0; b_lat = 0; s_bresp = 2'b00;
        exp_q.push_back('{rdata: 32'h0, resp: 2'b00, to: 1'b0});
        run_cmd(1'b1, 5'h08, 32'h0000_00A5, 4'hF, 0);
        e = exp_q.pop_front();
        tests_run++; if (obs_ready0 !== 1'b1) begin tests_failed++; $display("FAIL wr_cmd_ready: got %b expected 1", obs_ready0); end
        tests_run++; if (obs_aw_first != 1 || obs_w_first != 1) begin tests_failed++; $display("FAIL wr_aw_w_cycle: got %0d/%0d expected 1/1", obs_aw_first, obs_w_first); end
        tests_run++; if (obs_bready_first != 2) begin tests_failed++; $display("FAIL wr_bready_cycle: got %0d expected 2", obs_bready_first); end
        tests_run++; if (obs_rsp_cyc != 3) begin tests_failed++; $display("FAIL wr_rsp_cycle: got %0d expected 3", obs_rsp_cyc); end
        tests_run++; if ({obs_rdata, obs_resp, obs_to} !== {e.rdata, e.resp, e.to}) begin tests_failed++; $display("FAIL wr_rsp: got %h/%b/%b expected %h/%b/%b", obs_rdata, obs_resp, obs_to, e.rdata, e.resp, e.to); end
        tests_run++; if ({cap_awaddr, cap_wdata, cap_wstrb} !== {5'h08, 32'hA5, 4'hF}) begin tests_failed++; $display("FAIL wr_payload: got %h/%h/%h expected 08/000000a5/f", cap_awaddr, cap_wdata, cap_wstrb); end
        tests_run++; if (obs_ready_after !== 1'b1 || obs_rsp_after !== 1'b0) begin tests_failed++; $display("FAIL wr_return_idle: got ready %b rsp %b expected 1 0", obs_ready_after, obs_rsp_after); end
    endtask

    task automatic test_read_team_slave();
        ar_lat = 1; r_lat = 1; s_rdata = 32'h0000_0020; s_rresp = 2'b00;
        exp_q.push_back('{rdata: 32'h20, resp: 2'b00, to: 1'b0});
        run_cmd(1'b0, 5'h0C, 32'h0, 4'h0, 0);
        e = exp_q.pop_front();
        tests_run++; if (obs_ar_first != 1 || obs_aw_first != -1) begin tests_failed++; $display("FAIL rd_ar_cycle: got ar %0d aw %0d expected 1 -1", obs_ar_first, obs_aw_first); end
        tests_run++; if (obs_rsp_cyc != 5) begin tests_failed++; $display("FAIL rd_rsp_cycle: got %0d expected 5", obs_rsp_cyc); end
        tests_run++; if ({obs_rdata, obs_resp, obs_to} !== {e.rdata, e.resp, e.to}) begin tests_failed++; $display("FAIL rd_rsp: got %h/%b/%b expected %h/%b/%b", obs_rdata, obs_resp, obs_to, e.rdata, e.resp, e.to); end
        tests_run++; if (cap_araddr !== 5'h0C) begin tests_failed++; $display("FAIL rd_araddr: got %h expected 0c", cap_araddr); end
        ar_lat = 0; r_lat = 0;
    endtask

    task automatic test_write_w_late();
        int b0;
        aw_lat = 0; w_lat = 3; b_lat = 0; s_bresp = 2'b00;
        b0 = b_consumed;
        exp_q.push_back('{rdata: 32'h0, resp: 2'b00, to: 1'b0});
        run_cmd(1'b1, 5'h10, 32'h1234_5678, 4'h3, 0);
        e = exp_q.pop_front();
        tests_run++; if (obs_aw_last != 1) begin tests_failed++; $display("FAIL wlate_aw_drop: got last %0d expected 1", obs_aw_last); end
        tests_run++; if (obs_w_last != 4) begin tests_failed++; $display("FAIL wlate_w_hold: got last %0d expected 4", obs_w_last); end
        tests_run++; if (obs_bready_first != 5 || obs_rsp_cyc != 6) begin tests_failed++; $display("FAIL wlate_timing: got bready %0d rsp %0d expected 5 6", obs_bready_first, obs_rsp_cyc); end
        tests_run++; if (b_consumed - b0 != 1) begin tests_failed++; $display("FAIL wlate_b_count: got %0d expected 1", b_consumed - b0); end
        tests_run++; if ({obs_resp, cap_wstrb, cap_wdata} !== {e.resp, 4'h3, 32'h1234_5678}) begin tests_failed++; $display("FAIL wlate_payload: got %b/%h/%h expected %b/3/12345678", obs_resp, cap_wstrb, cap_wdata, e.resp); end
        w_lat = 0;
    endtask

    task automatic test_read_slverr_hold();
        ar_lat = 0; r_lat = 0; s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b10;
        exp_q.push_back('{rdata: 32'hDEAD_BEEF, resp: 2'b10, to: 1'b0});
        run_cmd(1'b0, 5'h04, 32'h0, 4'h0, 4);
        e = exp_q.pop_front();
        tests_run++; if ({obs_rdata, obs_resp} !== {e.rdata, e.resp}) begin tests_failed++; $display("FAIL slverr_rsp: got %h/%b expected %h/%b", obs_rdata, obs_resp, e.rdata, e.resp); end
        tests_run++; if (obs_rsp_len != 5) begin tests_failed++; $display("FAIL slverr_hold_len: got %0d expected 5", obs_rsp_len); end
        tests_run++; if (obs_unstable != 0) begin tests_failed++; $display("FAIL slverr_stable: got %0d changes expected 0", obs_unstable); end
        tests_run++; if (obs_ready_after !== 1'b1) begin tests_failed++; $display("FAIL slverr_ready_after: got %b expected 1", obs_ready_after); end
        s_rresp = 2'b00;
    endtask

    task automatic test_reset_mid();
        aw_lat = 0; w_lat = 0; b_lat = 40;
        @(negedge clk);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 5'h08; cmd_wdata = 32'h55; cmd_wstrb = 4'hF;
        @(negedge clk); cmd_valid = 0;
        @(negedge clk);
        tests_run++; if (M_AXI_BREADY !== 1'b1) begin tests_failed++; $display("FAIL rstmid_in_wr_resp: got bready %b expected 1", M_AXI_BREADY); end
        @(negedge clk);
        #2 rst = 1;
        #1;
        tests_run++;
        if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY, rsp_valid, busy, cmd_ready} !== 8'b0) begin
            tests_failed++; $display("FAIL rstmid_outputs: got %b expected 0",
                {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY, rsp_valid, busy, cmd_ready});
        end
        @(negedge clk);
        rst = 0; b_lat = 0;
        #1;
        tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL rstmid_ready: got %b expected 1", cmd_ready); end
        s_rdata = 32'hCAFE_0001; s_rresp = 2'b00;
        exp_q.push_back('{rdata: 32'hCAFE_0001, resp: 2'b00, to: 1'b0});
        run_cmd(1'b0, 5'h0C, 32'h0, 4'h0, 0);
        e = exp_q.pop_front();
        tests_run++; if ({obs_rdata, obs_resp, obs_to} !== {e.rdata, e.resp, e.to} || obs_rsp_cyc != 3) begin tests_failed++; $display("FAIL rstmid_next_cmd: got %h/%b cyc %0d expected %h/%b cyc 3", obs_rdata, obs_resp, obs_rsp_cyc, e.rdata, e.resp); end
    endtask

    task automatic test_back_to_back();
        logic       wr;
        logic [4:0] addr;
        logic [31:0] wd;
        logic [3:0] ws;
        for (int i = 0; i < 8; i++) begin
            wr = 1'($urandom); addr = {3'($urandom), 2'b00}; wd = $urandom; ws = 4'($urandom);
            aw_lat = $urandom_range(0, 2); w_lat = $urandom_range(0, 2); ar_lat = $urandom_range(0, 2);
            b_lat = $urandom_range(0, 2); r_lat = $urandom_range(0, 2);
            s_bresp = 2'($urandom); s_rresp = 2'($urandom); s_rdata = $urandom;
            if (wr) exp_q.push_back('{rdata: 32'h0, resp: s_bresp, to: 1'b0});
            else    exp_q.push_back('{rdata: s_rdata, resp: s_rresp, to: 1'b0});
            run_cmd(wr, addr, wd, ws, $urandom_range(0, 2));
            e = exp_q.pop_front();
            tests_run++; if ({obs_rdata, obs_resp, obs_to} !== {e.rdata, e.resp, e.to}) begin tests_failed++; $display("FAIL b2b_rsp[%0d]: got %h/%b/%b expected %h/%b/%b", i, obs_rdata, obs_resp, obs_to, e.rdata, e.resp, e.to); end
            tests_run++;
            if (wr ? ({cap_awaddr, cap_wdata, cap_wstrb} !== {addr, wd, ws}) : (cap_araddr !== addr)) begin
                tests_failed++; $display("FAIL b2b_payload[%0d]: got aw %h w %h s %h ar %h expected addr %h data %h strb %h", i, cap_awaddr, cap_wdata, cap_wstrb, cap_araddr, addr, wd, ws);
            end
            tests_run++; if (obs_ready0 !== 1'b1 || obs_ready_after !== 1'b1 || obs_unstable != 0) begin tests_failed++; $display("FAIL b2b_handshake[%0d]: got ready0 %b after %b unstable %0d expected 1 1 0", i, obs_ready0, obs_ready_after, obs_unstable); end
        end
        aw_lat = 0; w_lat = 0; ar_lat = 0; b_lat = 0; r_lat = 0; s_bresp = 0; s_rresp = 0;
    endtask

`ifdef AXI_CMD_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int r0, extra, waited;
        ar_lat = 30; r_lat = 2; s_rdata = 32'h1234; s_rresp = 2'b00;
        r0 = r_consumed;
        exp_q.push_back('{rdata: 32'h0, resp: 2'b10, to: 1'b1});
        run_cmd(1'b0, 5'h0C, 32'h0, 4'h0, 0);
        e = exp_q.pop_front();
        tests_run++; if (obs_rsp_cyc != 17) begin tests_failed++; $display("FAIL to_cycle: got %0d expected 17", obs_rsp_cyc); end
        tests_run++; if ({obs_rdata, obs_resp, obs_to} !== {e.rdata, e.resp, e.to}) begin tests_failed++; $display("FAIL to_rsp: got %h/%b/%b expected %h/%b/%b", obs_rdata, obs_resp, obs_to, e.rdata, e.resp, e.to); end
        tests_run++; if (obs_ready_after !== 1'b0) begin tests_failed++; $display("FAIL to_drain_busy: got cmd_ready %b expected 0", obs_ready_after); end
        extra = 0; waited = 0;
        while (busy && waited < 100) begin
            @(negedge clk);
            if (rsp_valid) extra++;
            waited++;
        end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL to_drain_done: got busy %b expected 0", busy); end
        tests_run++; if (extra != 0 || r_consumed - r0 != 1) begin tests_failed++; $display("FAIL to_drain: got extra rsp %0d r %0d expected 0 1", extra, r_consumed - r0); end
        ar_lat = 0; r_lat = 0;
    endtask
`endif

    task automatic test_protocol();
        tests_run++; if (viol != 0) begin tests_failed++; $display("FAIL axi_protocol: got %0d violations expected 0", viol); end
        tests_run++; if (cap_prot !== 3'b000) begin tests_failed++; $display("FAIL axi_prot: got %b expected 000", cap_prot); end
        tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL scoreboard_left: got %0d expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_team_slave();
        test_write_w_late();
        test_read_slverr_hold();
        test_reset_mid();
        test_back_to_back();
`ifdef AXI_CMD_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
